// File: rtl/shifter_feeder_pkg.sv
// Shared matmul constants and the feeder FSM state type.
// Defaults match the shifter bank and PE array geometry.
package shifter_feeder_pkg;

    localparam int DEF_LANES  = 16;
    localparam int DEF_LENGTH = 16;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_STREAM,
        ST_DONE
    } state_e;

endpackage

// File: rtl/shifter_feeder_if.sv
// Control, memory and shifter-bank signals of the feeder.
// master drives start/base/rdata; slave is the feeder itself.
interface shifter_feeder_if
    import shifter_feeder_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int LENGTH = DEF_LENGTH,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_rdata;
    logic [LANES-1:0]  sh_load;
    logic [WIDTH-1:0]  sh_idata;
    logic [LANES-1:0]  sh_en;
    logic [LANES-1:0]  lane_vld;

    modport master (
        output start, base_addr, mem_rdata,
        input  busy, done, mem_rd, mem_addr,
        input  sh_load, sh_idata, sh_en, lane_vld
    );

    modport slave (
        input  start, base_addr, mem_rdata,
        output busy, done, mem_rd, mem_addr,
        output sh_load, sh_idata, sh_en, lane_vld
    );

endinterface

// File: rtl/shifter_feeder_skew_gen.sv
// Diagonal wavefront mask: lane r is active for stream
// counts r .. r+LENGTH-1.
module skew_gen
    import shifter_feeder_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int LENGTH = DEF_LENGTH,
    parameter int SW     = 5
) (
    input  logic [SW-1:0]    s_i,
    output logic [LANES-1:0] mask_o
);

    // per-lane window compare against the stream count
    always_comb begin
        mask_o = '0;
        for (int r = 0; r < LANES; r++) begin
            mask_o[r] = (int'(s_i) >= r) &&
                        (int'(s_i) <= r + LENGTH - 1);
        end
    end

endmodule

// File: rtl/shifter_feeder.sv
// Loads a LANES x LENGTH tile into the operand shifters, then
// streams it out as a staggered diagonal wavefront.
module shifter_feeder
    import shifter_feeder_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int LENGTH = DEF_LENGTH,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input logic             clk,
    input logic             rst,
    shifter_feeder_if.slave bus
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int EW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int SW = $clog2(LANES + LENGTH);
    localparam logic [WIDTH-1:0] ZW = '0;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [EW-1:0]     elem_q, elem_d;
    logic [SW-1:0]     scnt_q, scnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LANES-1:0]  ld_q, ld_d;
    logic [LANES-1:0]  en_q, en_d;
    logic [LANES-1:0]  mask;

    skew_gen #(
        .LANES  (LANES),
        .LENGTH (LENGTH),
        .SW     (SW)
    ) u_skew (
        .s_i    (scnt_d),
        .mask_o (mask)
    );

    // next state, counters and next-cycle output values
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        lane_d  = lane_q;
        elem_d  = elem_q;
        scnt_d  = scnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        rd_d    = 1'b0;
        addr_d  = addr_q;
        ld_d    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    base_d  = bus.base_addr;
                    lane_d  = '0;
                    elem_d  = EW'(LENGTH - 1);
                    busy_d  = 1'b1;
                    rd_d    = 1'b1;
                end
            end
            ST_LOAD: begin
                busy_d = 1'b1;
                ld_d   = LANES'(1) << lane_q;
                if (elem_q == '0) begin
                    if (lane_q == LW'(LANES - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        lane_d = lane_q + 1'b1;
                        elem_d = EW'(LENGTH - 1);
                        rd_d   = 1'b1;
                    end
                end else begin
                    elem_d = elem_q - 1'b1;
                    rd_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                busy_d  = 1'b1;
                state_d = ST_STREAM;
                scnt_d  = '0;
            end
            ST_STREAM: begin
                if (scnt_q == SW'(LANES + LENGTH - 2)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    scnt_d = scnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (rd_d) begin
            addr_d = base_d
                   + ADDR_W'(lane_d) * ADDR_W'(LENGTH)
                   + ADDR_W'(elem_d);
        end
    end

    // shift enables follow the wavefront while streaming
    always_comb begin
        en_d = '0;
        if (state_d == ST_STREAM) begin
            en_d = mask;
        end
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            lane_q  <= '0;
            elem_q  <= '0;
            scnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            ld_q    <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            lane_q  <= lane_d;
            elem_q  <= elem_d;
            scnt_q  <= scnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            ld_q    <= ld_d;
            en_q    <= en_d;
        end
    end

    // load data is the memory output word, qualified by a load
    assign bus.sh_idata = (|ld_q) ? bus.mem_rdata : ZW;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mem_rd   = rd_q;
    assign bus.mem_addr = addr_q;
    assign bus.sh_load  = ld_q;
    assign bus.sh_en    = en_q;
    assign bus.lane_vld = en_q;

endmodule

// File: tb/tb_shifter_feeder.sv
// Scoreboard bench for shifter_feeder: 4x4 tile instance plus
// a 1x4 instance with a 4-bit address bus for wrap-around.
module tb_shifter_feeder;

    typedef struct {
        int cyc;
        int lane;
        int val;
    } ev_t;

    localparam int BIG = 1000000;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    ev_t q_addr[2][$];
    ev_t q_load[2][$];
    ev_t q_mask[2][$];
    ev_t q_done[2][$];
    ev_t q_lane[4][$];
    int  sh[4][$];

    shifter_feeder_if #(
        .LANES(4), .LENGTH(4), .WIDTH(32), .ADDR_W(16)
    ) b0 ();

    shifter_feeder_if #(
        .LANES(1), .LENGTH(4), .WIDTH(32), .ADDR_W(4)
    ) b1 ();

    shifter_feeder #(
        .LANES(4), .LENGTH(4), .WIDTH(32), .ADDR_W(16)
    ) u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    shifter_feeder #(
        .LANES(1), .LENGTH(4), .WIDTH(32), .ADDR_W(4)
    ) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memories hold mem[a] = a, one cycle read latency
    always @(posedge clk) begin
        if (b0.mem_rd) b0.mem_rdata <= 32'(b0.mem_addr);
        if (b1.mem_rd) b1.mem_rdata <= 32'(b1.mem_addr);
    end

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic unexp(input string nm, input int w);
        total++;
        bad++;
        $display("FAIL %s dut%0d @cyc %0d: unexpected event",
                 nm, w, cyc);
    endtask

    task automatic push_run(input int w, input int ln,
                            input int le, input int aw,
                            input int base, input int c0,
                            input int cut);
        ev_t e;
        int  t;
        int  a;
        int  m;
        for (int r = 0; r < ln; r++) begin
            for (int k = le - 1; k >= 0; k--) begin
                t = c0 + 1 + r * le + (le - 1 - k);
                a = (base + r * le + k) % (1 << aw);
                e.cyc = t; e.lane = r; e.val = a;
                if (t < cut) q_addr[w].push_back(e);
                e.cyc = t + 1;
                if (t + 1 < cut) q_load[w].push_back(e);
            end
        end
        for (int s = 0; s < ln + le - 1; s++) begin
            t = c0 + ln * le + 2 + s;
            m = 0;
            for (int r = 0; r < ln; r++) begin
                if (s >= r && s <= r + le - 1) m |= (1 << r);
            end
            e.cyc = t; e.lane = 0; e.val = m;
            if (t < cut) q_mask[w].push_back(e);
        end
        if (w == 0) begin
            for (int r = 0; r < ln; r++) begin
                for (int k = 0; k < le; k++) begin
                    t = c0 + ln * le + 2 + r + k;
                    e.cyc = t; e.lane = r;
                    e.val = (base + r * le + k) % (1 << aw);
                    if (t < cut) q_lane[r].push_back(e);
                end
            end
        end
        t = c0 + ln * le + ln + le + 1;
        e.cyc = t; e.lane = 0; e.val = 1;
        if (t < cut) q_done[w].push_back(e);
    endtask

    task automatic mon(input int w, input bit rd, input int addr,
                       input int ld, input int dat, input int en,
                       input int vld, input bit dn, input bit bsy);
        ev_t e;
        if (rd) begin
            if (q_addr[w].size() == 0) unexp("read", w);
            else begin
                e = q_addr[w].pop_front();
                chk("rd_cyc", cyc, e.cyc);
                chk("rd_addr", addr, e.val);
            end
        end
        if (ld != 0) begin
            chk("ld_onehot", int'($onehot0(ld)), 1);
            chk("ld_en_excl", ld & en, 0);
            if (q_load[w].size() == 0) unexp("load", w);
            else begin
                e = q_load[w].pop_front();
                chk("ld_cyc", cyc, e.cyc);
                chk("ld_lane", ld, 1 << e.lane);
                chk("ld_data", dat, e.val);
            end
        end
        if (en != 0 || vld != 0) begin
            chk("vld_vs_en", vld, en);
            if (q_mask[w].size() == 0) unexp("shift", w);
            else begin
                e = q_mask[w].pop_front();
                chk("en_cyc", cyc, e.cyc);
                chk("en_mask", en, e.val);
            end
        end
        if (dn) begin
            chk("done_busy", bsy, 0);
            if (q_done[w].size() == 0) unexp("done", w);
            else begin
                e = q_done[w].pop_front();
                chk("done_cyc", cyc, e.cyc);
            end
        end
    endtask

    // monitor: pops expectations whenever the DUTs present output
    always @(negedge clk) begin
        ev_t e;
        mon(0, b0.mem_rd, int'(b0.mem_addr), int'(b0.sh_load),
            int'(b0.sh_idata), int'(b0.sh_en),
            int'(b0.lane_vld), b0.done, b0.busy);
        mon(1, b1.mem_rd, int'(b1.mem_addr), int'(b1.sh_load),
            int'(b1.sh_idata), int'(b1.sh_en),
            int'(b1.lane_vld), b1.done, b1.busy);
        for (int r = 0; r < 4; r++) begin
            if (b0.lane_vld[r]) begin
                if (q_lane[r].size() == 0) unexp("lane_out", r);
                else begin
                    e = q_lane[r].pop_front();
                    chk("lane_cyc", cyc, e.cyc);
                    if (sh[r].size() == 0) unexp("lane_empty", r);
                    else chk("lane_data", sh[r][0], e.val);
                end
            end
            if (b0.sh_en[r] && sh[r].size() > 0)
                void'(sh[r].pop_front());
            if (b0.sh_load[r]) begin
                sh[r].push_front(int'(b0.sh_idata));
                if (sh[r].size() > 4) void'(sh[r].pop_back());
            end
        end
    end

    task automatic go(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_u0"}, longint'({b0.busy, b0.done, b0.mem_rd,
            b0.mem_addr, b0.sh_load, b0.sh_idata, b0.sh_en,
            b0.lane_vld}), 0);
        chk({nm, "_u1"}, longint'({b1.busy, b1.done, b1.mem_rd,
            b1.mem_addr, b1.sh_load, b1.sh_idata, b1.sh_en,
            b1.lane_vld}), 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        b0.start = 1'b0; b0.base_addr = '0; b0.mem_rdata = '0;
        b1.start = 1'b0; b1.base_addr = '0; b1.mem_rdata = '0;
        go(2);
        chk_zero("reset_outs");
        go(3);
        rst = 1'b0;
        // baseline tile, start sampled at end of cycle 5
        go(5);
        b0.start = 1'b1; b0.base_addr = 16'h10;
        push_run(0, 4, 4, 16, 'h10, 5, BIG);
        go(6);
        b0.start = 1'b0;
        // start while busy must be ignored
        go(15);
        b0.start = 1'b1; b0.base_addr = 16'h40;
        chk("busy_mid", b0.busy, 1);
        go(16);
        b0.start = 1'b0;
        // start during DONE ignored, next cycle accepted
        go(30);
        b0.start = 1'b1;
        go(31);
        b0.base_addr = 16'h20;
        push_run(0, 4, 4, 16, 'h20, 31, BIG);
        go(32);
        b0.start = 1'b0;
        // reset in cycle 9 of a tile
        go(60);
        b0.start = 1'b1; b0.base_addr = 16'h30;
        push_run(0, 4, 4, 16, 'h30, 60, 70);
        go(61);
        b0.start = 1'b0;
        go(69);
        rst = 1'b1;
        go(70);
        rst = 1'b0;
        chk_zero("midrst_outs");
        // fresh tile at 0 plus address wrap on the small DUT
        go(72);
        b0.start = 1'b1; b0.base_addr = 16'h0;
        b1.start = 1'b1; b1.base_addr = 4'hE;
        push_run(0, 4, 4, 16, 0, 72, BIG);
        push_run(1, 1, 4, 4, 'hE, 72, BIG);
        go(73);
        b0.start = 1'b0;
        b1.start = 1'b0;
        go(105);
        for (int w = 0; w < 2; w++) begin
            chk("left_addr", q_addr[w].size(), 0);
            chk("left_load", q_load[w].size(), 0);
            chk("left_mask", q_mask[w].size(), 0);
            chk("left_done", q_done[w].size(), 0);
        end
        for (int r = 0; r < 4; r++)
            chk("left_lane", q_lane[r].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shifter_feeder.md
# shifter_feeder

Load-and-skew controller that sits directly upstream of the bank of `LANES` operand shifters feeding the matmul systolic array. On `start` it reads a `LANES`×`LENGTH` row-major operand tile from a 1-cycle-latency memory and serially loads each lane's shifter. It then drives staggered per-lane shift enables so that lane `r` presents its first element `r` cycles after lane 0, which is the diagonal wavefront the array expects. It raises `done` when the last element has left the shifters.

## Interface
- `LANES`, 16: number of shifter lanes, equal to the tile rows.
- `LENGTH`, 16: shifter depth, equal to the elements per row.
- `WIDTH`, 32: data word width.
- `ADDR_W`, 16: memory address width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a tile; sampled only in IDLE.
- `base_addr` in `ADDR_W`: tile base address, latched when `start` is accepted.
- `busy` out 1: high in LOAD, DRAIN and STREAM.
- `done` out 1: one-cycle pulse at the end of the tile.
- `mem_rd` out 1: read strobe.
- `mem_addr` out `ADDR_W`: read address.
- `mem_rdata` in `WIDTH`: read data, valid the cycle after `mem_rd`.
- `sh_load` out `LANES`: per-lane load strobe, one-hot or zero.
- `sh_idata` out `WIDTH`: shared load data bus.
- `sh_en` out `LANES`: per-lane shift enable.
- `lane_vld` out `LANES`: lane `r`'s shifter output holds a valid element this cycle.

## Operation
- **FSM states:** IDLE → LOAD → DRAIN → STREAM → DONE → IDLE.
- **IDLE:** `start`=1 latches `base_addr` and moves to LOAD.
- **LOAD:** issues exactly `LANES*LENGTH` reads, one per cycle, with no gaps.
  - Order: lane `r` = 0..`LANES`-1 outer, element `k` = `LENGTH`-1 down to 0 inner.
  - Address = `base + r*LENGTH + k`, truncated modulo 2^`ADDR_W`.
  - Elements are loaded in descending `k` because a shifter emits its last-loaded word first. Its output therefore shows element 0 first, then 1, and so on.
- **Read pipeline:** one stage. The read issued in cycle t produces `sh_load[r]`=1 and `sh_idata`=`mem_rdata` in cycle t+1.
- **DRAIN:** one cycle carrying the final load. No read is issued.
- **STREAM:** lasts `LANES+LENGTH-1` cycles, with stream cycle index s = 0...
  - `sh_en[r]` and `lane_vld[r]` are both high for r ≤ s ≤ r+`LENGTH`-1.
- **DONE:** `done`=1 for one cycle, `busy`=0, then IDLE.
- **`start` outside IDLE:** ignored. This includes the DONE cycle.
- **Output exclusivity:** `sh_load` and `sh_en` are never high in the same cycle. At most one `sh_load` bit is high.
- **Reset:** `rst`, including mid-operation, forces IDLE.
  - All outputs go to 0: `busy`, `done`, `mem_rd`, `mem_addr`, `sh_load`, `sh_idata`, `sh_en`, `lane_vld`.
  - Partially loaded shifter contents are not cleared; the next tile overwrites them completely.

## Timing
- All outputs are registered.
- The cycle numbers below assume `start` is sampled high at the end of cycle 0.
- LOAD covers cycles 1..`LANES*LENGTH`, with `mem_rd` high throughout.
- Loads occur in cycles 2..`LANES*LENGTH`+1; the last of these is the DRAIN cycle.
- STREAM covers cycles `LANES*LENGTH`+2 .. `LANES*LENGTH`+`LANES`+`LENGTH`.
- `done` rises in cycle `LANES*LENGTH+LANES+LENGTH+1`.
- The earliest next `start` is accepted one cycle after `done`.
- **Degenerate sizes:**
  - `LANES`=1: STREAM is `LENGTH` cycles.
  - `LENGTH`=1: each lane takes one read, and STREAM is `LANES` cycles.

## Structure
- The shared matmul package holds:
  - the state enum (IDLE, LOAD, DRAIN, STREAM, DONE);
  - default `LANES`/`LENGTH`/`WIDTH` constants, shared with the shifter and PE array.
- Counters: lane (log2 `LANES`), element (log2 `LENGTH`), stream (log2(`LANES`+`LENGTH`)).
- One natural sub-module, `skew_gen`: given stream count s, it produces the `sh_en`/`lane_vld` window mask. It is reused for the other operand edge of the array.

## Test plan
- **Baseline tile:** `LANES`=`LENGTH`=4, mem[a]=a, `base_addr`=0x10, start in cycle 0.
  - `mem_addr` sequence is 0x13,0x12,0x11,0x10,0x17…0x1C.
  - `sh_load[0]` in cycles 2–5 with data 0x13..0x10.
  - `done` in cycle 25.
- **Stagger window:** same run.
  - `sh_en[2]`=`lane_vld[2]`=1 exactly in cycles 20–23.
  - `sh_en[0]` in cycles 18–21.
  - `sh_en[3]` in cycles 21–24.
  - A shifter model's lane 1 output reads 0x14,0x15,0x16,0x17 on its valid cycles.
- **`start` while busy:** pulse `start` at cycle 10 and in the DONE cycle.
  - No restart; `base_addr` stays unchanged.
  - The next start is accepted at cycle 26.
- **Mid-operation reset:** assert `rst` at cycle 9.
  - Cycle 10: all outputs 0, state IDLE.
  - A new start with `base_addr`=0 completes normally, and all lane outputs match mem[0..15].
- **Address wrap:** `ADDR_W`=4, `base_addr`=0xE, `LENGTH`=4, `LANES`=1.
  - Addresses are 0x1, 0x0, 0xF, 0xE.
